// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//   Shares one single-port synchronous memory between three requesters:
//   the host loader/debug port (h_*), the CPU data port (d_*) and the CPU
//   instruction fetch port (i_*, read-only). Stalls the CPU whenever one of
//   its requests loses arbitration. It also lets the host own the memory
//   for a whole program-load session (h_lock).
//
//   Handshake: a requester raises *_req with stable address/data and keeps
//   them stable until the cycle in which *_gnt=1. The grant is combinational
//   in that same cycle, and the access is performed on the following clock
//   edge. A granted read returns its data on rdata one cycle later, flagged
//   by that requester's *_rvalid for exactly one cycle. Writes never raise
//   *_rvalid. There is no queue inside the arbiter.
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-high reset
//   h_req/h_lock/h_we/h_addr/h_wdata -> h_gnt/h_rvalid   host port
//   d_req/d_we/d_addr/d_wdata        -> d_gnt/d_rvalid   CPU data port
//   i_req/i_addr                     -> i_gnt/i_rvalid   CPU fetch port
//   rdata                    shared read data (= m_rdata)
//   m_addr/m_we/m_wdata      memory request, muxed from the winner
//   m_rdata                  memory read data, one cycle after the read
//   cpu_stall                a CPU request is pending and not granted
//   host_owns                arbiter FSM is in the HOST state
//   dbg_wait_cnt             fetch starvation counter (debug visibility)
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4,
  parameter int WCW      = $clog2(MAX_WAIT + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           h_req,
  input  logic           h_lock,
  input  logic           h_we,
  input  logic [AW-1:0]  h_addr,
  input  logic [DW-1:0]  h_wdata,
  output logic           h_gnt,
  output logic           h_rvalid,
  input  logic           d_req,
  input  logic           d_we,
  input  logic [AW-1:0]  d_addr,
  input  logic [DW-1:0]  d_wdata,
  output logic           d_gnt,
  output logic           d_rvalid,
  input  logic           i_req,
  input  logic [AW-1:0]  i_addr,
  output logic           i_gnt,
  output logic           i_rvalid,
  output logic [DW-1:0]  rdata,
  output logic [AW-1:0]  m_addr,
  output logic           m_we,
  output logic [DW-1:0]  m_wdata,
  input  logic [DW-1:0]  m_rdata,
  output logic           cpu_stall,
  output logic           host_owns,
  output logic [WCW-1:0] dbg_wait_cnt
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOST = 1'b1
  } state_t;

  state_t         r_state;
  logic [WCW-1:0] r_wait_cnt;
  logic           r_h_rvalid;
  logic           r_d_rvalid;
  logic           r_i_rvalid;

  logic w_run;
  logic w_i_boost;
  logic w_h_gnt;
  logic w_d_gnt;
  logic w_i_gnt;

  assign w_run     = (r_state == ST_RUN);
  // Fetch has been starved long enough: it now outranks the data port.
  assign w_i_boost = (r_wait_cnt == WCW'(MAX_WAIT));

  // The host wins in RUN and is the only requester served in HOST, so its
  // grant reduces to its own request. CPU ports are only served in RUN
  // when the host is quiet. Nothing is granted while reset is high.
  assign w_h_gnt = ~reset & h_req;
  assign w_d_gnt = ~reset & w_run & ~h_req & d_req & ~(i_req & w_i_boost);
  assign w_i_gnt = ~reset & w_run & ~h_req & i_req & (~d_req | w_i_boost);

  assign h_gnt = w_h_gnt;
  assign d_gnt = w_d_gnt;
  assign i_gnt = w_i_gnt;

  // Memory request mux; all zero when nobody is granted.
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_we    = 1'b0;
    if (w_h_gnt) begin
      m_addr  = h_addr;
      m_wdata = h_wdata;
      m_we    = h_we;
    end else if (w_d_gnt) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_we    = d_we;
    end else if (w_i_gnt) begin
      m_addr  = i_addr;
    end
  end

  assign cpu_stall    = ~reset & ((i_req & ~w_i_gnt) | (d_req & ~w_d_gnt));
  assign host_owns    = (r_state == ST_HOST);
  assign dbg_wait_cnt = r_wait_cnt;
  assign rdata        = m_rdata;

  // A read response falling in a reset cycle is dropped, not delivered.
  assign h_rvalid = r_h_rvalid & ~reset;
  assign d_rvalid = r_d_rvalid & ~reset;
  assign i_rvalid = r_i_rvalid & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_h_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rvalid <= 1'b0;
    end else begin
      r_h_rvalid <= w_h_gnt & ~h_we;
      r_d_rvalid <= w_d_gnt & ~d_we;
      r_i_rvalid <= w_i_gnt;
      case (r_state)
        ST_RUN: begin
          if (h_req) r_state <= ST_HOST;
          if (!i_req || w_i_gnt) begin
            r_wait_cnt <= '0;
          end else if (!w_i_boost) begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
          end
        end
        ST_HOST: begin
          // Starvation counter is frozen while the host owns memory.
          if (!h_req && !h_lock) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 4;
  localparam int WCW      = $clog2(MAX_WAIT + 1);
  localparam int EW       = 32 + 3 + DW;

  localparam int W_NONE = 0;
  localparam int W_H    = 1;
  localparam int W_D    = 2;
  localparam int W_I    = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           reset;
  logic           h_req, h_lock, h_we;
  logic [AW-1:0]  h_addr;
  logic [DW-1:0]  h_wdata;
  logic           h_gnt, h_rvalid;
  logic           d_req, d_we;
  logic [AW-1:0]  d_addr;
  logic [DW-1:0]  d_wdata;
  logic           d_gnt, d_rvalid;
  logic           i_req;
  logic [AW-1:0]  i_addr;
  logic           i_gnt, i_rvalid;
  logic [DW-1:0]  rdata;
  logic [AW-1:0]  m_addr;
  logic           m_we;
  logic [DW-1:0]  m_wdata;
  logic [DW-1:0]  m_rdata;
  logic           cpu_stall, host_owns;
  logic [WCW-1:0] dbg_wait_cnt;

  unified_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset),
    .h_req(h_req), .h_lock(h_lock), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .rdata(rdata), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .cpu_stall(cpu_stall), .host_owns(host_owns),
    .dbg_wait_cnt(dbg_wait_cnt)
  );

  // Unified memory the arbiter drives: synchronous, one-cycle read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (m_we) mem[m_addr] <= m_wdata;
    m_rdata <= mem[m_addr];
  end

  int cyc = 0;
  always @(negedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];   // {due cycle, {h,d,i} rvalid, data}
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: ownership mode, fetch starvation count, memory image.
  bit            mdl_host;
  int            mdl_wait;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            last_win;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Checks the combinational response of the current cycle, then advances
  // the reference model across the upcoming clock edge.
  task automatic tick();
    int win;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic ewe, estall;
    #1;
    win = W_NONE;
    if (!reset) begin
      if (mdl_host)             win = h_req ? W_H : W_NONE;
      else if (h_req)           win = W_H;
      else if (d_req && i_req)  win = (mdl_wait >= MAX_WAIT) ? W_I : W_D;
      else if (d_req)           win = W_D;
      else if (i_req)           win = W_I;
    end
    ea = '0; ed = '0; ewe = 1'b0;
    case (win)
      W_H: begin ea = h_addr; ed = h_wdata; ewe = h_we; end
      W_D: begin ea = d_addr; ed = d_wdata; ewe = d_we; end
      W_I: begin ea = i_addr; end
      default: ;
    endcase
    estall = !reset && ((i_req && win != W_I) || (d_req && win != W_D));

    check("ctl{hg,dg,ig,we,stall,own}",
          {58'd0, h_gnt, d_gnt, i_gnt, m_we, cpu_stall, host_owns},
          {58'd0, win == W_H, win == W_D, win == W_I, ewe, estall, mdl_host});
    check("m_addr", 64'(m_addr), 64'(ea));
    check("m_wdata", 64'(m_wdata), 64'(ed));
    check("wait_cnt", 64'(dbg_wait_cnt), 64'(mdl_wait));

    if (reset) begin
      exp_q.delete();
      mdl_host = 1'b0;
      mdl_wait = 0;
    end else begin
      if (win == W_H || win == W_D) begin
        if (ewe) ref_mem[ea] = ed;
        else exp_q.push_back({32'(cyc + 1), (win == W_H) ? 3'b100 : 3'b010, ref_mem[ea]});
      end else if (win == W_I) begin
        exp_q.push_back({32'(cyc + 1), 3'b001, ref_mem[ea]});
      end
      if (mdl_host) begin
        mdl_host = h_req || h_lock;
      end else begin
        mdl_host = h_req;
        if (i_req && win != W_I) mdl_wait = (mdl_wait < MAX_WAIT) ? mdl_wait + 1 : MAX_WAIT;
        else mdl_wait = 0;
      end
    end
    last_win = win;
    @(negedge clock);
  endtask

  task automatic idle();
    h_req = 0; h_lock = 0; h_we = 0; d_req = 0; d_we = 0; i_req = 0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    logic [2:0]    exp_rv;
    logic [DW-1:0] exp_d;
    bit            have;
    forever begin
      @(negedge clock);
      #2;
      exp_rv = 3'b000; exp_d = '0; have = 0;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (e[EW-1:EW-32] == 32'(cyc)) begin
          void'(exp_q.pop_front());
          exp_rv = e[DW+2:DW];
          exp_d  = e[DW-1:0];
          have   = 1;
        end
      end
      check("rvalid{h,d,i}", 64'({h_rvalid, d_rvalid, i_rvalid}), 64'(exp_rv));
      if (have) check("rdata", 64'(rdata), 64'(exp_d));
    end
  end

  // ---------------- stimulus ----------------
  int h_sess;

  initial begin
    for (int k = 0; k < (1 << AW); k++) begin
      ref_mem[k] = DW'($urandom);
      mem[k]     = ref_mem[k];
    end
    mdl_host = 0; mdl_wait = 0; last_win = W_NONE; h_sess = 0;
    reset = 1; idle();
    h_addr = '0; h_wdata = '0; d_addr = '0; d_wdata = '0; i_addr = '0;
    @(negedge clock);

    // Reset with every requester active: nothing may be granted.
    h_req = 1; h_we = 1; d_req = 1; i_req = 1;
    tick();
    reset = 0; idle();
    tick();

    // Fetch-only reads at 0x00..0x03.
    for (int a = 0; a < 4; a++) begin
      i_req = 1; i_addr = AW'(a);
      tick();
    end
    idle(); tick();

    // Data write and fetch collide; data wins, fetch follows, read back.
    d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 16'hBEEF;
    i_req = 1; i_addr = 8'h05;
    tick();
    d_req = 0; d_we = 0;
    tick();
    i_req = 0; d_req = 1; d_addr = 8'h10;
    tick();
    idle(); tick();

    // Fetch starvation: data requests every cycle, fetch held.
    i_req = 1; i_addr = 8'h07;
    for (int n = 0; n < 8; n++) begin
      d_req = 1; d_we = 0; d_addr = AW'($urandom_range(0, 31));
      if (last_win == W_I) i_addr = AW'($urandom_range(0, 31));
      tick();
    end
    idle(); tick();

    // Host lock session writing 0x00..0x07, CPU ports held off.
    h_lock = 1; d_req = 1; d_addr = 8'h20; i_req = 1; i_addr = 8'h03;
    for (int a = 0; a < 8; a++) begin
      h_req = 1; h_we = 1; h_addr = AW'(a); h_wdata = DW'($urandom);
      tick();
    end
    h_req = 0; h_we = 0;
    tick();
    h_lock = 0;
    tick();
    d_req = 0;
    tick();
    tick();
    idle(); tick();

    // Host access without lock: one HOST cycle, then back to RUN.
    h_req = 1; h_we = 0; h_addr = 8'h02; i_req = 1; i_addr = 8'h01;
    tick();
    h_req = 0;
    tick();
    tick();
    idle(); tick();

    // Reset clears the starvation count.
    d_req = 1; d_addr = 8'h11; i_req = 1; i_addr = 8'h04;
    tick(); tick();
    reset = 1;
    tick();
    reset = 0; idle(); tick();

    // Reset in the cycle after a fetch grant drops its response.
    i_req = 1; i_addr = 8'h02;
    tick();
    reset = 1; i_addr = 8'h09;
    tick();
    reset = 0;
    for (int a = 0; a < 4; a++) begin
      i_req = 1; i_addr = AW'(a);
      tick();
    end
    idle(); tick();

    // Randomised traffic with host sessions and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (last_win == W_H) begin h_req = 0; h_we = 0; end
      if (last_win == W_D) begin d_req = 0; d_we = 0; end
      if (last_win == W_I) i_req = 0;
      reset = ($urandom_range(0, 299) == 0);
      if (h_sess > 0) begin
        h_sess--;
        h_lock = (h_sess > 0);
        if (!h_req && $urandom_range(0, 1) == 1) begin
          h_req = 1; h_we = 1'($urandom_range(0, 1));
          h_addr = AW'($urandom_range(0, 31)); h_wdata = DW'($urandom);
        end
      end else begin
        h_lock = 0;
        if (!h_req && $urandom_range(0, 49) == 0) begin
          h_req = 1; h_we = 1'($urandom_range(0, 1));
          h_addr = AW'($urandom_range(0, 31)); h_wdata = DW'($urandom);
          if ($urandom_range(0, 1) == 1) h_sess = $urandom_range(3, 12);
        end
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom_range(0, 31)); d_wdata = DW'($urandom);
      end
      if (!i_req && $urandom_range(0, 3) != 0) begin
        i_req = 1; i_addr = AW'($urandom_range(0, 31));
      end
      tick();
    end

    reset = 0; idle();
    for (int n = 0; n < 4; n++) tick();
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
